// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first, a
// programmable number of times, with an optional idle gap between repetitions.
module sequence_generator #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic [3:0]       gap_len,
  output logic             aout,
  output logic             aout_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_count
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [3:0]       gap_q, gap_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             aout_q, aout_d;
  logic             vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d   = pattern;
          reps_d  = reps;
          gap_d   = gap_len;
          gcnt_d  = '0;
          sent_d  = '0;
          idx_d   = IDX_MSB;
          state_d = (reps == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (idx_q == '0) begin
          sent_d = sent_q + 1'b1;
          idx_d  = IDX_MSB;
          if (sent_d == reps_q) begin
            state_d = DONE;
          end else if (gap_q != 4'd0) begin
            // Counter runs gap_len-1 down to 0, giving exactly gap_len idle cycles.
            state_d = GAP;
            gcnt_d  = gap_q - 4'd1;
          end
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      GAP: begin
        if (gcnt_q == 4'd0) state_d = SEND;
        else                gcnt_d  = gcnt_q - 4'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Output bit is computed from next state so aout is a true register.
    vld_d  = (state_d == SEND);
    aout_d = vld_d ? pat_d[idx_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      sent_q  <= '0;
      aout_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
      aout_q  <= aout_d;
      vld_q   <= vld_d;
    end
  end

  assign aout       = aout_q;
  assign aout_valid = vld_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign sent_count = sent_q;

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
- Serial pattern transmitter; the source end of the single-bit serial line that sequence detectors consume (drives their ain input).
- Latches a PAT_W-bit pattern and transmits it MSB-first, one bit per clock, a programmable number of times.
- An optional idle gap separates repetitions.
- Provides a start/busy/done handshake and a count of patterns sent, for driving detector benches and on-board demos.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
CNT_W, 4, width of repetition request and sent counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a transmission; sampled only in IDLE
pattern  input  PAT_W  bit pattern to send, MSB first; latched on accepted start
reps  input  CNT_W  number of pattern repetitions; latched on accepted start
gap_len  input  4  idle cycles between repetitions; latched on accepted start
aout  output  1  serial data bit, registered
aout_valid  output  1  high while aout carries a pattern bit
busy  output  1  high in SEND, GAP and DONE
done  output  1  one-cycle pulse after the final bit
sent_count  output  CNT_W  patterns fully sent in the current job

Behaviour:
- Reset (synchronous, active-high):
  - All outputs and internal registers go to 0 at the next edge with reset=1.
  - State goes to IDLE.
  - Reset mid-job aborts immediately; no done pulse is generated.
- FSM states: IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 at edge E0: latch pattern/reps/gap_len, clear sent_count, clear bit index.
  - If reps≠0, go to SEND; if reps=0, go directly to DONE (no bits sent, sent_count stays 0).
- SEND:
  - The cycle after E0 shows aout=pattern[PAT_W-1] and aout_valid=1. Each following cycle shows the next lower bit. Latency from start edge to first bit = 1 cycle.
  - At the edge where bit 0 has been presented, sent_count increments.
  - If the new count equals reps, go to DONE.
  - Otherwise, if gap_len=0, stay in SEND and present the MSB again on the next cycle (back-to-back, no bubble).
  - Otherwise go to GAP.
- GAP:
  - aout=0 and aout_valid=0 for exactly gap_len cycles, then return to SEND at the MSB.
- DONE:
  - Lasts one cycle: done=1, busy=1, aout=0, aout_valid=0.
  - Returns to IDLE at the next edge.
- Outputs outside SEND: aout=0 and aout_valid=0 in IDLE, GAP and DONE.
- busy=0 only in IDLE.
- start while busy=1 is ignored, including during DONE. Changes to pattern, reps or gap_len while busy have no effect on the running job.
- start held high continuously: a new job is accepted on the first IDLE cycle after DONE. Minimum spacing between jobs is one IDLE cycle.
- sent_count holds its final value in IDLE until the next accepted start. Maximum value is 2^CNT_W-1 (reps max), so it never wraps.
- Bit index counter width is clog2(PAT_W); it wraps to PAT_W-1 at each pattern restart.

Test Plan:
1. Single pattern: reset 2 cycles, then pattern=4'b1011, reps=1, gap_len=0, start pulse.
   - Expect aout=1,0,1,1 with aout_valid=1 on cycles 1-4 after the start edge.
   - Expect done=1 on cycle 5, sent_count=1, busy low on cycle 6.
2. Back-to-back repeats: pattern=4'b1101, reps=3, gap_len=0.
   - Expect 12 consecutive valid bits 110111011101, then done, sent_count=3.
3. Gapped repeats: pattern=4'b1001, reps=2, gap_len=3.
   - Expect 1001, then 3 cycles with aout_valid=0, then 1001, then done.
   - Expect total busy duration of 12 cycles.
4. Zero reps: reps=0, start.
   - Expect no aout_valid, done pulse on cycle 1, sent_count=0.
5. Reset mid-job: reps=5, assert reset during the 2nd pattern.
   - Expect all outputs 0 the next cycle, no done pulse.
   - A subsequent start runs normally.
6. Ignored start and changed inputs: during a reps=2 job, pulse start and change pattern.
   - Expect the original pattern sent twice, exactly one done pulse.
   - Also connect aout to a detector and check its count against sent_count.
